// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Multi-channel event front end. Each channel has:
//   - an edge or pulse detector,
//   - a pending flag,
//   - a sticky overflow flag.
//   A round-robin scheduler hands the detected events, one at a time, to a
//   single consumer over a valid/ready port.
//
// Ports
//   clk       clock, everything on posedge
//   rst       asynchronous, active-high reset
//   a         N input lines, synchronous to clk
//   mode      per channel: 0 = rising edge, 1 = one-cycle 0-1-0 pulse
//   ev_valid  event offered
//   ev_ready  consumer accepts when ev_valid && ev_ready
//   ev_id     channel of the offered event
//   ev_ovf    at least one further event on ev_id was lost while it was pending
//   pending   per-channel pending flags (status/debug)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | output stage empty, ev_valid=0, waiting for a pending flag
// S_OFFER | ev_id/ev_ovf offered with ev_valid=1, held until handshake

module edge_event_arbiter #(
   parameter  int N   = 4,
   localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   mode,
   output logic           ev_valid,
   input  logic           ev_ready,
   output logic [IDW-1:0] ev_id,
   output logic           ev_ovf,
   output logic [N-1:0]   pending
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_OFFER = 1'b1
   } state_t;

   state_t         state;
   logic [N-1:0]   a_d1;
   logic [N-1:0]   a_d2;
   logic [N-1:0]   pend_q;
   logic [N-1:0]   ovf_q;
   logic [IDW-1:0] rr_ptr;

   logic [N-1:0]   det;
   logic [N-1:0]   clr;
   logic [N-1:0]   pend_d;
   logic [N-1:0]   ovf_d;
   logic           win_found;
   logic [IDW-1:0] win_idx;
   logic [IDW-1:0] next_ptr;
   logic [IDW-1:0] cand_idx;
   logic           load;
   int             cand;

   // Pulse mode needs a two-deep history.
   // It fires on the falling edge of a 0-1-0 shape, so a level held for two
   // or more cycles is rejected.
   always_comb begin
      det = (~mode & a & ~a_d1) | (mode & ~a & a_d1 & ~a_d2);
   end

   // Pick the first pending channel at or above rr_ptr, wrapping modulo N.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int off = 0; off < N; off++) begin
         cand     = (int'(rr_ptr) + off) % N;
         cand_idx = IDW'(cand);
         if (!win_found && pend_q[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
      next_ptr = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
   end

   // The output stage is refilled either from IDLE or on a handshake.
   // Pending is sampled before this cycle's detections are merged in.
   always_comb begin
      load = win_found && ((state == S_IDLE) || ev_ready);
      clr  = load ? (N'(1) << win_idx) : '0;
   end

   // A detection on the channel being loaded re-arms pending rather than
   // counting as a loss: the previous event has just left the channel.
   always_comb begin
      pend_d = (pend_q & ~clr) | det;
      ovf_d  = (ovf_q & ~(clr & ~det)) | (det & pend_q & ~clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_d1     <= '0;
         a_d2     <= '0;
         pend_q   <= '0;
         ovf_q    <= '0;
         rr_ptr   <= '0;
         state    <= S_IDLE;
         ev_valid <= 1'b0;
         ev_id    <= '0;
         ev_ovf   <= 1'b0;
      end else begin
         a_d1   <= a;
         a_d2   <= a_d1;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         case (state)
            S_IDLE: begin
               if (load) begin
                  ev_valid <= 1'b1;
                  ev_id    <= win_idx;
                  ev_ovf   <= ovf_q[win_idx];
                  rr_ptr   <= next_ptr;
                  state    <= S_OFFER;
               end
            end
            S_OFFER: begin
               if (ev_ready) begin
                  if (load) begin
                     ev_id  <= win_idx;
                     ev_ovf <= ovf_q[win_idx];
                     rr_ptr <= next_ptr;
                  end else begin
                     ev_valid <= 1'b0;
                     state    <= S_IDLE;
                  end
               end
            end
            default: begin
               ev_valid <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

   assign pending = pend_q;

   // An offer is only withdrawn or changed through a handshake.
   a_hold_valid : assert property (@(posedge clk) disable iff (rst)
      (ev_valid && !ev_ready) |=> ev_valid);
   a_hold_id : assert property (@(posedge clk) disable iff (rst)
      (ev_valid && !ev_ready) |=> ($stable(ev_id) && $stable(ev_ovf)));

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] a;
   logic [3:0] mode;
   logic       ev_valid;
   logic       ev_ready;
   logic [1:0] ev_id;
   logic       ev_ovf;
   logic [3:0] pending;

   int errors = 0;
   int checks = 0;

   edge_event_arbiter #(.N(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .mode     (mode),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_id    (ev_id),
      .ev_ovf   (ev_ovf),
      .pending  (pending)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      a        = 4'h0;
      mode     = 4'h0;
      ev_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      a        = 4'hF;
      mode     = 4'h0;
      ev_ready = 1'b0;
      step();
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ev_valid); end
      checks++; if (ev_id !== 2'd0)    begin errors++; $display("FAIL reset_id: got %0d expected 0", ev_id); end
      checks++; if (ev_ovf !== 1'b0)   begin errors++; $display("FAIL reset_ovf: got %b expected 0", ev_ovf); end
      checks++; if (pending !== 4'h0)  begin errors++; $display("FAIL reset_pending: got %h expected 0", pending); end
      rst = 1'b0;
      step();
      checks++; if (pending !== 4'hF)  begin errors++; $display("FAIL reset_first_edge_pending: got %h expected f", pending); end
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_first_edge_valid: got %b expected 0", ev_valid); end
      step();
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd0) begin errors++; $display("FAIL reset_first_offer: got valid=%b id=%0d expected valid=1 id=0", ev_valid, ev_id); end
      checks++; if (pending !== 4'hE)  begin errors++; $display("FAIL reset_first_offer_pending: got %h expected e", pending); end
      ev_ready = 1'b1;
      repeat (4) step();
      checks++; if (ev_valid !== 1'b0 || pending !== 4'h0) begin errors++; $display("FAIL reset_drain: got valid=%b pending=%h expected valid=0 pending=0", ev_valid, pending); end
   endtask

   task automatic test_rising();
      int seen;
      do_reset();
      ev_ready = 1'b1;
      step();
      a = 4'b0100;
      step();
      checks++; if (pending !== 4'b0100 || ev_valid !== 1'b0) begin errors++; $display("FAIL rise_pending: got pending=%b valid=%b expected 0100/0", pending, ev_valid); end
      step();
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd2) begin errors++; $display("FAIL rise_offer: got valid=%b id=%0d expected 1/2", ev_valid, ev_id); end
      step();
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rise_single: got valid=%b expected 0", ev_valid); end
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (ev_valid !== 1'b0 || pending !== 4'h0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rise_hold_no_event: got %0d active cycles expected 0", seen); end
   endtask

   task automatic test_pulse();
      int seen;
      do_reset();
      mode     = 4'b0010;
      ev_ready = 1'b1;
      step();
      a = 4'b0010;
      step();
      a = 4'b0000;
      step();
      checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL pulse_pending: got %b expected 0010", pending); end
      step();
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd1) begin errors++; $display("FAIL pulse_offer: got valid=%b id=%0d expected 1/1", ev_valid, ev_id); end
      step();
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL pulse_single: got valid=%b expected 0", ev_valid); end
      a = 4'b0010;
      step();
      step();
      a = 4'b0000;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (ev_valid !== 1'b0 || pending !== 4'h0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL pulse_wide_rejected: got %0d active cycles expected 0", seen); end
      a = 4'b0001;
      step();
      checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL pulse_ch0_edge_pending: got %b expected 0001", pending); end
      a = 4'b0000;
      step();
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd0) begin errors++; $display("FAIL pulse_ch0_offer: got valid=%b id=%0d expected 1/0", ev_valid, ev_id); end
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (ev_valid !== 1'b0 || pending !== 4'h0) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL pulse_ch0_single: got %0d active cycles expected 0", seen); end
   endtask

   task automatic test_round_robin();
      int exp_a[4];
      int exp_b[4];
      exp_a = '{0, 1, 2, 3};
      exp_b = '{2, 3, 0, 1};
      do_reset();
      ev_ready = 1'b1;
      step();
      a = 4'hF;
      step();
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (ev_valid !== 1'b1 || int'(ev_id) != exp_a[k]) begin errors++; $display("FAIL rr_a[%0d]: got valid=%b id=%0d expected 1/%0d", k, ev_valid, ev_id, exp_a[k]); end
      end
      step();
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rr_a_end: got valid=%b expected 0", ev_valid); end
      a = 4'h0;
      step();
      step();
      a = 4'b0010;
      step();
      step();
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd1) begin errors++; $display("FAIL rr_setup: got valid=%b id=%0d expected 1/1", ev_valid, ev_id); end
      step();
      a = 4'h0;
      step();
      step();
      a = 4'hF;
      step();
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (ev_valid !== 1'b1 || int'(ev_id) != exp_b[k]) begin errors++; $display("FAIL rr_b[%0d]: got valid=%b id=%0d expected 1/%0d", k, ev_valid, ev_id, exp_b[k]); end
      end
      step();
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rr_b_end: got valid=%b expected 0", ev_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      step();
      a = 4'b1000;
      step();
      a = 4'b0000;
      step();
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd3 || ev_ovf !== 1'b0) begin errors++; $display("FAIL bp_first: got valid=%b id=%0d ovf=%b expected 1/3/0", ev_valid, ev_id, ev_ovf); end
      checks++; if (pending !== 4'h0) begin errors++; $display("FAIL bp_first_pending: got %b expected 0000", pending); end
      a = 4'b1000;
      step();
      a = 4'b0000;
      step();
      a = 4'b1000;
      step();
      a = 4'b0000;
      step();
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd3 || ev_ovf !== 1'b0) begin errors++; $display("FAIL bp_held: got valid=%b id=%0d ovf=%b expected 1/3/0", ev_valid, ev_id, ev_ovf); end
      checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL bp_pending: got %b expected 1000", pending); end
      ev_ready = 1'b1;
      step();
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd3 || ev_ovf !== 1'b1) begin errors++; $display("FAIL bp_second: got valid=%b id=%0d ovf=%b expected 1/3/1", ev_valid, ev_id, ev_ovf); end
      checks++; if (pending !== 4'h0) begin errors++; $display("FAIL bp_second_pending: got %b expected 0000", pending); end
      step();
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL bp_end: got valid=%b expected 0", ev_valid); end
      ev_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      do_reset();
      step();
      a = 4'b0001;
      step();
      a = 4'b0000;
      step();
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd0 || pending !== 4'h0) begin errors++; $display("FAIL sim_setup: got valid=%b id=%0d pending=%b expected 1/0/0000", ev_valid, ev_id, pending); end
      a = 4'b0001;
      step();
      a = 4'b0000;
      step();
      a        = 4'b0001;
      ev_ready = 1'b1;
      step();
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd0 || ev_ovf !== 1'b0) begin errors++; $display("FAIL sim_reload: got valid=%b id=%0d ovf=%b expected 1/0/0", ev_valid, ev_id, ev_ovf); end
      checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL sim_rearm_pending: got %b expected 0001", pending); end
      step();
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd0 || ev_ovf !== 1'b0 || pending !== 4'h0) begin errors++; $display("FAIL sim_no_ovf: got valid=%b id=%0d ovf=%b pending=%b expected 1/0/0/0000", ev_valid, ev_id, ev_ovf, pending); end
      step();
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL sim_end: got valid=%b expected 0", ev_valid); end

      ev_ready = 1'b0;
      a        = 4'b0000;
      step();
      a = 4'b0001;
      step();
      step();
      checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL abort_setup: got valid=%b expected 1", ev_valid); end
      a   = 4'b0000;
      rst = 1'b1;
      #1;
      checks++; if (ev_valid !== 1'b0 || pending !== 4'h0) begin errors++; $display("FAIL abort_immediate: got valid=%b pending=%b expected 0/0000", ev_valid, pending); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      step();
      checks++; if (ev_valid !== 1'b0 || pending !== 4'h0) begin errors++; $display("FAIL abort_after: got valid=%b pending=%b expected 0/0000", ev_valid, pending); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst      = 1'b1;
      a        = 4'hF;
      mode     = 4'h0;
      ev_ready = 1'b0;
      test_reset();
      test_rising();
      test_pulse();
      test_round_robin();
      test_backpressure();
      test_simultaneous();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
